img_uart_sender: RTL and testbench
==================================

Name: img_uart_sender

Overview:
- Reads a stored RGB444 image out of the frame RAM and streams it over a UART TX line as 8N1.
- Uses the same frame format the image receiver accepts:
  - 0x5A header;
  - two bytes per pixel, {pix[11:4]} then {pix[3:0],4'b0000};
  - 0x5A trailer.
- Sits on the RAM read port beside the receive path, so the board can echo or dump the stored frame back to the host.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 9600, line rate. BIT_CYC = CLK_FREQ/BAUD_RATE (integer truncation, must be >= 4).
- ADDR_W, 15, RAM address width.
- PIX_W, 12, pixel width (RGB444).
- FRAME_TAG, 8'h5A, header/trailer byte.

Ports:
- i_clk_sys  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  start request, sampled only in IDLE.
- i_pix_total  in  ADDR_W  pixel count, latched on accepted start.
- o_ram_addr  out  ADDR_W  RAM read address.
- o_ram_rden  out  1  one-cycle read strobe.
- i_ram_dout  in  PIX_W  RAM data, valid exactly 1 cycle after o_ram_rden.
- o_tx  out  1  UART serial out, idle high.
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: o_tx=1, o_busy=0, o_done=0, o_ram_rden=0, o_ram_addr=0, state IDLE, all counters 0.
- Reset asserted mid-frame: o_tx=1 from the next edge and the frame is abandoned; no trailer, no o_done.
- Byte engine:
  - Start bit 0, 8 data bits LSB first, 1 stop bit; each bit held exactly BIT_CYC cycles.
  - One byte = 10*BIT_CYC cycles.
  - Bytes are back to back: the next start bit begins the cycle after the previous stop bit ends.
- Top FSM states: IDLE, HDR, PIX_HI, PIX_LO, CSUM (optional), TRL, DONE.
- IDLE:
  - i_start=1 at edge N: latch i_pix_total, o_busy=1 and o_tx=0 (header start bit) from edge N+1.
  - i_start while busy is ignored.
- HDR: sends FRAME_TAG. Next state is PIX_HI if total>0, else TRL.
- Prefetch rule: pixel k is read when the byte preceding its high byte starts.
  - That byte is the header for k=0, and the PIX_LO byte of pixel k-1 otherwise.
  - Read: o_ram_rden=1 for one cycle with o_ram_addr=k. i_ram_dout is captured into a pixel register the following cycle.
  - At most one read per pixel; addresses 0..total-1, ascending, no wrap.
- PIX_HI sends pix[11:4]. PIX_LO sends {pix[3:0],4'b0}.
- Pixel counter is ADDR_W bits, incremented after PIX_LO. When it equals total, next state is TRL (or CSUM).
- TRL: sends FRAME_TAG.
- DONE, in the cycle after the trailer stop bit ends:
  - o_done=1 for 1 cycle and o_busy=0, return to IDLE.
  - A new i_start is accepted in that same cycle.
- Total frame length: (2*total+2)*10*BIT_CYC cycles from the first start bit to the end of the trailer stop bit.
- i_pix_total=0: header then trailer only, no RAM reads.
- Maximum total is 2^ADDR_W-1 = 32767.

Optional Feature:
- IMG_TX_CHECKSUM_EN defined:
  - State CSUM is inserted between the last PIX_LO and TRL.
  - It sends the 8-bit XOR of all pixel bytes, header excluded. For total=0 it sends 0x00.
  - Frame length becomes (2*total+3)*10*BIT_CYC.
- Undefined: no CSUM state, no checksum logic.

Test Plan (all with CLK_FREQ=50, BAUD_RATE=10, so BIT_CYC=5):
- Reset then i_start with total=0 -> o_tx bytes 0x5A,0x5A; o_done pulses 100 cycles after the first start bit; o_ram_rden never asserts.
- RAM preloaded 0xABC,0x123, total=2 -> bytes 5A,AB,C0,12,30,5A; reads at addr 0 then 1, each one cycle wide; no idle gap between bytes.
- total=20 with random RAM contents -> bench UART decoder rebuilds all 20 pixels bit-exact; o_busy high for exactly 420*5 cycles.
- i_start pulsed again during the frame -> ignored; only one frame sent; a start in the o_done cycle launches a second frame.
- i_rst asserted during pixel 3 -> o_tx=1 the next cycle, o_busy=0, no o_done; a later start sends a full correct frame.
- IMG_TX_CHECKSUM_EN defined, pixels 0xABC,0x123 -> bytes 5A,AB,C0,12,30,49,5A (0x49 = AB^C0^12^30).

Source files
------------

// File: rtl/img_uart_sender_if.sv
// Handshake and RAM-read bundle for img_uart_sender.
// master: the sender side; slave: the host/RAM side.
interface img_uart_sender_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PIX_W  = 12
);
  logic              i_start;
  logic [ADDR_W-1:0] i_pix_total;
  logic [ADDR_W-1:0] o_ram_addr;
  logic              o_ram_rden;
  logic [PIX_W-1:0]  i_ram_dout;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start,
    input  i_pix_total,
    input  i_ram_dout,
    output o_ram_addr,
    output o_ram_rden,
    output o_tx,
    output o_busy,
    output o_done
  );

  modport slave (
    output i_start,
    output i_pix_total,
    output i_ram_dout,
    input  o_ram_addr,
    input  o_ram_rden,
    input  o_tx,
    input  o_busy,
    input  o_done
  );
endinterface

// File: rtl/img_uart_sender.sv
// Streams a stored RGB444 frame from RAM over a UART TX line (8N1): tag, pixel bytes, tag.
// Optional checksum byte before the trailer when IMG_TX_CHECKSUM_EN is defined.
module img_uart_sender #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned PIX_W     = 12,
  parameter logic [7:0]  FRAME_TAG = 8'h5A
) (
  input logic               i_clk_sys,
  input logic               i_rst,
  img_uart_sender_if.master bus
);

  localparam int unsigned BitCyc = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CycW   = (BitCyc > 1) ? $clog2(BitCyc) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(BitCyc - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr   = 3'd1,
    StPixHi = 3'd2,
    StPixLo = 3'd3,
`ifdef IMG_TX_CHECKSUM_EN
    StCsum  = 3'd6,
`endif
    StTrl   = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Byte engine
  logic            tx_q;
  logic [8:0]      shreg_q;
  logic [CycW-1:0] cyc_q;
  logic [3:0]      bit_q;

  logic [ADDR_W-1:0] total_q, total_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;
  logic              rden_q;
  logic              cap_q;
  logic [PIX_W-1:0]  pix_q;

  logic       load;
  logic [7:0] load_byte;
  logic [7:0] pix_hi;
  logic [7:0] pix_lo;
  logic       busy;
  logic       byte_end;

`ifdef IMG_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign byte_end = busy && (cyc_q == CycLast) && (bit_q == 4'd9);
  assign cnt_inc  = cnt_q + ADDR_W'(1);
  assign pix_hi   = pix_q[PIX_W-1 -: 8];
  assign pix_lo   = {pix_q[3:0], 4'b0000};

  // Next-state: every byte transition loads the following byte at the same edge,
  // so there is never an idle gap between bytes of a frame.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_byte = FRAME_TAG;
    rd_req    = 1'b0;
    rd_addr   = cnt_inc;
`ifdef IMG_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.i_start) begin
          state_d = StHdr;
          load    = 1'b1;
          total_d = bus.i_pix_total;
          cnt_d   = '0;
          // Pixel 0 is prefetched while the header goes out.
          rd_req  = (bus.i_pix_total != '0);
          rd_addr = '0;
`ifdef IMG_TX_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StHdr: begin
        if (byte_end) begin
          load = 1'b1;
          if (total_q != '0) begin
            state_d   = StPixHi;
            load_byte = pix_hi;
`ifdef IMG_TX_CHECKSUM_EN
            csum_d    = csum_q ^ pix_hi;
`endif
          end else begin
`ifdef IMG_TX_CHECKSUM_EN
            state_d   = StCsum;
            load_byte = csum_q;
`else
            state_d   = StTrl;
`endif
          end
        end
      end
      StPixHi: begin
        if (byte_end) begin
          state_d   = StPixLo;
          load      = 1'b1;
          load_byte = pix_lo;
          rd_req    = (cnt_inc != total_q);
`ifdef IMG_TX_CHECKSUM_EN
          csum_d    = csum_q ^ pix_lo;
`endif
        end
      end
      StPixLo: begin
        if (byte_end) begin
          load  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == total_q) begin
`ifdef IMG_TX_CHECKSUM_EN
            state_d   = StCsum;
            load_byte = csum_q;
`else
            state_d   = StTrl;
`endif
          end else begin
            state_d   = StPixHi;
            load_byte = pix_hi;
`ifdef IMG_TX_CHECKSUM_EN
            csum_d    = csum_q ^ pix_hi;
`endif
          end
        end
      end
`ifdef IMG_TX_CHECKSUM_EN
      StCsum: begin
        if (byte_end) begin
          state_d = StTrl;
          load    = 1'b1;
        end
      end
`endif
      StTrl: begin
        if (byte_end) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q <= StIdle;
      total_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      cap_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      rden_q  <= rd_req;
      cap_q   <= rden_q;
      if (rd_req) begin
        addr_q <= rd_addr;
      end
      // RAM data is valid the cycle after the strobe.
      if (cap_q) begin
        pix_q <= bus.i_ram_dout;
      end
    end
  end

`ifdef IMG_TX_CHECKSUM_EN
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Start bit is driven on load; shreg holds data LSB first followed by the stop bit.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      tx_q    <= 1'b1;
      shreg_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
    end else if (load) begin
      tx_q    <= 1'b0;
      shreg_q <= {1'b1, load_byte};
      cyc_q   <= '0;
      bit_q   <= '0;
    end else if (busy) begin
      if (cyc_q == CycLast) begin
        cyc_q <= '0;
        if (bit_q != 4'd9) begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b1, shreg_q[8:1]};
        end
      end else begin
        cyc_q <= cyc_q + CycW'(1);
      end
    end else begin
      tx_q  <= 1'b1;
      cyc_q <= '0;
      bit_q <= '0;
    end
  end

  assign bus.o_tx       = tx_q;
  assign bus.o_busy     = busy;
  assign bus.o_done     = (state_q == StDone);
  assign bus.o_ram_rden = rden_q;
  assign bus.o_ram_addr = addr_q;

endmodule

// File: tb/tb_img_uart_sender.sv
// Directed bench for img_uart_sender at BIT_CYC=5: decodes o_tx and checks frames,
// RAM read pattern, timing, restart and mid-frame reset.
module tb_img_uart_sender;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned PIX_W  = 12;
  localparam int ByteCyc = 50;
`ifdef IMG_TX_CHECKSUM_EN
  localparam int CsumBytes = 1;
`else
  localparam int CsumBytes = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [PIX_W-1:0] mem [64];
  logic [7:0] exp_b [$];

  // Monitor state, written only by the negedge monitor.
  logic [7:0] rx_b [$];
  int         rx_t [$];
  int         rd_log [$];
  int         rd_cyc [$];
  int         busy_cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         busy_in_done = 0;
  int         rd_wide = 0;
  int         framing_err = 0;
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_t = 0;
  logic [7:0] mon_sh = 8'h00;
  logic       prev_rden = 1'b0;

  img_uart_sender_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  img_uart_sender #(
    .CLK_FREQ (50),
    .BAUD_RATE(10),
    .ADDR_W   (ADDR_W),
    .PIX_W    (PIX_W),
    .FRAME_TAG(8'h5A)
  ) dut (
    .i_clk_sys(clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.o_ram_rden) bus.i_ram_dout <= mem[bus.o_ram_addr[5:0]];
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_act   = 1'b0;
      prev_rden = 1'b0;
    end else begin
      if (bus.o_busy === 1'b1) busy_cyc++;
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (bus.o_busy !== 1'b0) busy_in_done++;
      end
      if (bus.o_ram_rden === 1'b1) begin
        rd_log.push_back(int'(bus.o_ram_addr));
        rd_cyc.push_back(cyc);
        if (prev_rden) rd_wide++;
      end
      prev_rden = (bus.o_ram_rden === 1'b1);
      if (!mon_act) begin
        if (bus.o_tx === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
          mon_t   = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2 && bus.o_tx !== 1'b0) framing_err++;
        if (mon_cnt >= 7 && mon_cnt <= 42 && (mon_cnt % 5) == 2) mon_sh = {bus.o_tx, mon_sh[7:1]};
        if (mon_cnt == 47) begin
          if (bus.o_tx !== 1'b1) framing_err++;
          rx_b.push_back(mon_sh);
          rx_t.push_back(mon_t);
        end
        if (mon_cnt == 49) mon_act = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1);
  end

  task automatic build_exp(input int total);
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    cs = 8'h00;
    exp_b.delete();
    exp_b.push_back(8'h5A);
    for (int i = 0; i < total; i++) begin
      hi = mem[i][11:4];
      lo = {mem[i][3:0], 4'h0};
      exp_b.push_back(hi);
      exp_b.push_back(lo);
      cs = cs ^ hi ^ lo;
    end
    if (CsumBytes != 0) exp_b.push_back(cs);
    exp_b.push_back(8'h5A);
  endtask

  task automatic start_frame(input int total);
    @(posedge clk); #1;
    bus.i_pix_total = ADDR_W'(total);
    bus.i_start     = 1'b1;
    @(posedge clk); #1;
    bus.i_start     = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_pix_total = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", bus.o_tx); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_ram_rden !== 1'b0) begin n_err++; $display("FAIL reset_rden got %b want 0", bus.o_ram_rden); end
    n_cmp++; if (bus.o_ram_addr !== ADDR_W'(0)) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.o_ram_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_tx !== 1'b1) begin n_err++; $display("FAIL idle_tx got %b want 1", bus.o_tx); end
  endtask

  task automatic test_zero_total();
    int b, r, d;
    bit ok;
    logic [7:0] got;
    b = rx_b.size(); r = rd_log.size(); d = done_cnt;
    exp_b = {8'h5A};
    if (CsumBytes != 0) exp_b.push_back(8'h00);
    exp_b.push_back(8'h5A);
    start_frame(0);
    wait_done(1000, ok);
    @(posedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL zero_done_seen got %b want 1", ok); end
    n_cmp++; if (rx_b.size() - b != exp_b.size()) begin n_err++; $display("FAIL zero_len got %0d want %0d", rx_b.size() - b, exp_b.size()); end
    for (int i = 0; i < exp_b.size(); i++) begin
      got = (b + i < rx_b.size()) ? rx_b[b + i] : 8'hxx;
      n_cmp++; if (got !== exp_b[i]) begin n_err++; $display("FAIL zero_byte%0d got %h want %h", i, got, exp_b[i]); end
    end
    if (b < rx_t.size()) begin
      n_cmp++;
      if (done_cyc - rx_t[b] != (2 + CsumBytes) * ByteCyc) begin
        n_err++; $display("FAIL zero_done_time got %0d want %0d", done_cyc - rx_t[b], (2 + CsumBytes) * ByteCyc);
      end
    end
    n_cmp++; if (rd_log.size() - r != 0) begin n_err++; $display("FAIL zero_rden got %0d reads want 0", rd_log.size() - r); end
    n_cmp++; if (done_cnt - d != 1) begin n_err++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_two_pixels();
    int b, r;
    bit ok;
    logic [7:0] got;
    mem[0] = 12'hABC;
    mem[1] = 12'h123;
    b = rx_b.size(); r = rd_log.size();
    exp_b = {8'h5A, 8'hAB, 8'hC0, 8'h12, 8'h30};
    if (CsumBytes != 0) exp_b.push_back(8'h49);
    exp_b.push_back(8'h5A);
    start_frame(2);
    wait_done(2000, ok);
    @(posedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL two_done_seen got %b want 1", ok); end
    n_cmp++; if (rx_b.size() - b != exp_b.size()) begin n_err++; $display("FAIL two_len got %0d want %0d", rx_b.size() - b, exp_b.size()); end
    for (int i = 0; i < exp_b.size(); i++) begin
      got = (b + i < rx_b.size()) ? rx_b[b + i] : 8'hxx;
      n_cmp++; if (got !== exp_b[i]) begin n_err++; $display("FAIL two_byte%0d got %h want %h", i, got, exp_b[i]); end
    end
    for (int i = 0; i + 1 < exp_b.size() && b + i + 1 < rx_t.size(); i++) begin
      n_cmp++;
      if (rx_t[b + i + 1] - rx_t[b + i] != ByteCyc) begin
        n_err++; $display("FAIL two_gap%0d got %0d want %0d", i, rx_t[b + i + 1] - rx_t[b + i], ByteCyc);
      end
    end
    n_cmp++; if (rd_log.size() - r != 2) begin n_err++; $display("FAIL two_nreads got %0d want 2", rd_log.size() - r); end
    if (rd_log.size() - r == 2 && rx_t.size() > b + 2) begin
      n_cmp++; if (rd_log[r] != 0) begin n_err++; $display("FAIL two_addr0 got %0d want 0", rd_log[r]); end
      n_cmp++; if (rd_log[r + 1] != 1) begin n_err++; $display("FAIL two_addr1 got %0d want 1", rd_log[r + 1]); end
      n_cmp++; if (rd_cyc[r] != rx_t[b]) begin n_err++; $display("FAIL two_rd0_time got %0d want %0d", rd_cyc[r], rx_t[b]); end
      n_cmp++; if (rd_cyc[r + 1] != rx_t[b + 2]) begin n_err++; $display("FAIL two_rd1_time got %0d want %0d", rd_cyc[r + 1], rx_t[b + 2]); end
    end
    if (b < rx_t.size()) begin
      n_cmp++;
      if (done_cyc - rx_t[b] != exp_b.size() * ByteCyc) begin
        n_err++; $display("FAIL two_frame_len got %0d want %0d", done_cyc - rx_t[b], exp_b.size() * ByteCyc);
      end
    end
  endtask

  task automatic test_twenty_pixels();
    int b, r, bc;
    bit ok;
    logic [7:0] got;
    logic [11:0] pix;
    for (int i = 0; i < 20; i++) mem[i] = 12'($urandom_range(0, 4095));
    build_exp(20);
    b = rx_b.size(); r = rd_log.size(); bc = busy_cyc;
    start_frame(20);
    wait_done(5000, ok);
    @(posedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t20_done_seen got %b want 1", ok); end
    n_cmp++; if (busy_cyc - bc != (42 + CsumBytes) * ByteCyc) begin n_err++; $display("FAIL t20_busy_cycles got %0d want %0d", busy_cyc - bc, (42 + CsumBytes) * ByteCyc); end
    n_cmp++; if (rx_b.size() - b != exp_b.size()) begin n_err++; $display("FAIL t20_len got %0d want %0d", rx_b.size() - b, exp_b.size()); end
    if (rx_b.size() - b == exp_b.size()) begin
      n_cmp++; if (rx_b[b] !== 8'h5A) begin n_err++; $display("FAIL t20_header got %h want 5a", rx_b[b]); end
      for (int i = 0; i < 20; i++) begin
        pix = {rx_b[b + 1 + 2 * i], rx_b[b + 2 + 2 * i][7:4]};
        n_cmp++; if (pix !== mem[i]) begin n_err++; $display("FAIL t20_pix%0d got %h want %h", i, pix, mem[i]); end
        n_cmp++; if (rx_b[b + 2 + 2 * i][3:0] !== 4'h0) begin n_err++; $display("FAIL t20_pad%0d got %h want 0", i, rx_b[b + 2 + 2 * i][3:0]); end
      end
      for (int i = 41; i < exp_b.size(); i++) begin
        got = rx_b[b + i];
        n_cmp++; if (got !== exp_b[i]) begin n_err++; $display("FAIL t20_tail%0d got %h want %h", i, got, exp_b[i]); end
      end
    end
    n_cmp++; if (rd_log.size() - r != 20) begin n_err++; $display("FAIL t20_nreads got %0d want 20", rd_log.size() - r); end
    for (int i = 0; i < 20 && r + i < rd_log.size(); i++) begin
      n_cmp++; if (rd_log[r + i] != i) begin n_err++; $display("FAIL t20_addr%0d got %0d want %0d", i, rd_log[r + i], i); end
    end
  endtask

  task automatic test_back_to_back();
    int b, d, t1, n1;
    bit ok, ok2;
    logic [7:0] got;
    mem[0] = 12'h5C3;
    build_exp(1);
    b = rx_b.size(); d = done_cnt; t1 = 0; n1 = 0;
    start_frame(1);
    repeat (60) @(posedge clk);
    start_frame(5);
    bus.i_pix_total = ADDR_W'(1);
    wait_done(2000, ok);
    t1 = cyc;
    n1 = rx_b.size() - b;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_done1_seen got %b want 1", ok); end
    n_cmp++; if (n1 != exp_b.size()) begin n_err++; $display("FAIL b2b_first_len got %0d want %0d", n1, exp_b.size()); end
    wait_done(2000, ok2);
    @(posedge clk);
    n_cmp++; if (ok2 !== 1'b1) begin n_err++; $display("FAIL b2b_done2_seen got %b want 1", ok2); end
    n_cmp++; if (done_cnt - d != 2) begin n_err++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt - d); end
    n_cmp++; if (rx_b.size() - b != 2 * exp_b.size()) begin n_err++; $display("FAIL b2b_len got %0d want %0d", rx_b.size() - b, 2 * exp_b.size()); end
    for (int i = 0; i < 2 * exp_b.size(); i++) begin
      got = (b + i < rx_b.size()) ? rx_b[b + i] : 8'hxx;
      n_cmp++; if (got !== exp_b[i % exp_b.size()]) begin n_err++; $display("FAIL b2b_byte%0d got %h want %h", i, got, exp_b[i % exp_b.size()]); end
    end
    if (b + exp_b.size() < rx_t.size()) begin
      n_cmp++;
      if (rx_t[b + exp_b.size()] != t1 + 1) begin
        n_err++; $display("FAIL b2b_restart_time got %0d want %0d", rx_t[b + exp_b.size()], t1 + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int b, r, d, b2;
    bit ok, ok2;
    logic [7:0] got;
    for (int i = 0; i < 6; i++) mem[i] = 12'(i * 12'h111 + 12'h0F0);
    b = rx_b.size(); r = rd_log.size(); d = done_cnt;
    start_frame(6);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      if (rx_b.size() - b >= 7) ok = 1'b1;
    end
    ok2 = 1'b0;
    for (int i = 0; i < 40 && !ok2; i++) begin
      @(negedge clk);
      if (bus.o_tx === 1'b0) ok2 = 1'b1;
    end
    rst = 1'b1;
    n_cmp++; if ((ok && ok2) !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_pix3 got %b%b want 11", ok, ok2); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_tx !== 1'b1) begin n_err++; $display("FAIL rstmid_tx got %b want 1", bus.o_tx); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    n_cmp++; if (done_cnt != d) begin n_err++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d); end
    n_cmp++; if (rx_b.size() - b != 7) begin n_err++; $display("FAIL rstmid_bytes got %0d want 7", rx_b.size() - b); end
    n_cmp++; if (rd_log.size() - r != 4) begin n_err++; $display("FAIL rstmid_nreads got %0d want 4", rd_log.size() - r); end
    for (int i = 0; i < 3; i++) mem[i] = 12'(12'hF0F - i * 12'h123);
    build_exp(3);
    b2 = rx_b.size();
    start_frame(3);
    wait_done(3000, ok);
    @(posedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_after_done got %b want 1", ok); end
    n_cmp++; if (rx_b.size() - b2 != exp_b.size()) begin n_err++; $display("FAIL rstmid_after_len got %0d want %0d", rx_b.size() - b2, exp_b.size()); end
    for (int i = 0; i < exp_b.size(); i++) begin
      got = (b2 + i < rx_b.size()) ? rx_b[b2 + i] : 8'hxx;
      n_cmp++; if (got !== exp_b[i]) begin n_err++; $display("FAIL rstmid_after_byte%0d got %h want %h", i, got, exp_b[i]); end
    end
  endtask

  task automatic test_global_rules();
    n_cmp++; if (rd_wide != 0) begin n_err++; $display("FAIL rden_one_cycle got %0d wide strobes want 0", rd_wide); end
    n_cmp++; if (framing_err != 0) begin n_err++; $display("FAIL uart_framing got %0d errors want 0", framing_err); end
    n_cmp++; if (busy_in_done != 0) begin n_err++; $display("FAIL busy_in_done got %0d want 0", busy_in_done); end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_pix_total = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_zero_total();
    test_two_pixels();
    test_twenty_pixels();
    test_back_to_back();
    test_reset_mid_frame();
    test_global_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
